// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared state encoding and default constants for debounce_sync
package debounce_pkg;

  typedef enum logic [1:0] {
    STABLE_LOW  = 2'd0,
    WAIT_HIGH   = 2'd1,
    STABLE_HIGH = 2'd2,
    WAIT_LOW    = 2'd3
  } state_t;

  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 4;

endpackage

// File: rtl/debounce_sync_if.sv
// rtl/debounce_sync_if.sv - raw input and conditioned outputs of debounce_sync
interface debounce_sync_if;

  logic raw_in;
  logic level_out;
  logic rise_pulse;
  logic fall_pulse;

  modport master (output raw_in, input level_out, input rise_pulse, input fall_pulse);
  modport slave  (input raw_in, output level_out, output rise_pulse, output fall_pulse);

endinterface

// File: rtl/debounce_sync_sync_chain.sv
// rtl/debounce_sync_sync_chain.sv - multi-flop synchroniser for an asynchronous input
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] r_stages;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stages <= '0;
    end else begin
      r_stages <= {r_stages[STAGES-2:0], d};
    end
  end

  assign q = r_stages[STAGES-1];

endmodule

// File: rtl/debounce_sync.sv
// rtl/debounce_sync.sv - synchronise and debounce a raw input into a clean level
// plus one-cycle rise/fall events
module debounce_sync
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic     clk,
  input  logic     reset,
  debounce_sync_if.slave bus
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             w_s;
  state_t           r_state, w_state;
  logic [CNT_W-1:0] r_cnt, w_cnt;
  logic             r_level, w_level;
  logic             r_rise, w_rise;
  logic             r_fall, w_fall;

  sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (bus.raw_in),
    .q     (w_s)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= STABLE_LOW;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_level <= w_level;
      r_rise  <= w_rise;
      r_fall  <= w_fall;
    end
  end

  // A change is accepted only after the counter has seen it hold for
  // DEBOUNCE_CYCLES more edges; any reversion drops back to the stable state.
  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_level = r_level;
    w_rise  = 1'b0;
    w_fall  = 1'b0;
    case (r_state)
      STABLE_LOW: begin
        if (w_s) begin
          w_state = WAIT_HIGH;
          w_cnt   = '0;
        end
      end
      WAIT_HIGH: begin
        if (!w_s) begin
          w_state = STABLE_LOW;
        end else if (r_cnt == CNT_LAST) begin
          w_state = STABLE_HIGH;
          w_level = 1'b1;
          w_rise  = 1'b1;
        end else begin
          w_cnt = r_cnt + CNT_ONE;
        end
      end
      STABLE_HIGH: begin
        if (!w_s) begin
          w_state = WAIT_LOW;
          w_cnt   = '0;
        end
      end
      WAIT_LOW: begin
        if (w_s) begin
          w_state = STABLE_HIGH;
        end else if (r_cnt == CNT_LAST) begin
          w_state = STABLE_LOW;
          w_level = 1'b0;
          w_fall  = 1'b1;
        end else begin
          w_cnt = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_state = STABLE_LOW;
      end
    endcase
  end

  assign bus.level_out  = r_level;
  assign bus.rise_pulse = r_rise;
  assign bus.fall_pulse = r_fall;

endmodule
